nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs a wide (4*N_NIBBLES-bit) addition by time-multiplexing one 4-bit ripple-carry adder, one nibble per clock, LSB nibble first.
- Latches operands on a start pulse and walks the nibble index, feeding the registered carry back as carry-in.
- Assembles the result and reports completion with a one-cycle done pulse.
- Sits between board-level operand capture (switches/registers) and display logic, replacing a wide combinational adder where area matters.

Parameters:
N_NIBBLES, 4, number of 4-bit slices; operand width W = 4*N_NIBBLES (legal range 2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
start  input  1  request a new addition; sampled only when ready
a  input  W  operand A, captured when start is accepted
b  input  W  operand B, captured when start is accepted
cin  input  1  carry-in to nibble 0, captured when start is accepted
ready  output  1  high when a start would be accepted (IDLE or DONE)
busy  output  1  high while in RUN
done  output  1  single-cycle pulse: sum/cout valid
sum  output  W  result, held stable from done until next accepted start
cout  output  1  carry-out of most significant nibble, held with sum

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high. No asynchronous reset anywhere.
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0. Internal operand regs, carry reg and index are all 0.
- States: IDLE, RUN, DONE.
  - IDLE: ready=1. If start=1 at the edge: capture a, b, cin into op_a, op_b, carry. Set idx=0 and go to RUN.
  - RUN: busy=1, ready=0. Adder inputs are op_a[4*idx+:4], op_b[4*idx+:4] and carry (combinational).
    - Each edge writes the adder sum into sum[4*idx+:4], carry<=adder cout, idx<=idx+1.
    - On the edge where idx==N_NIBBLES-1: cout<=adder cout and go to DONE.
  - DONE: done=1 for exactly this one cycle, ready=1.
    - start=1 at the edge: capture new operands and go to RUN (back-to-back, no IDLE bubble).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0. Nibbles are committed at edges E1..EN. done is high in the cycle after EN. Total N_NIBBLES+1 cycles from acceptance to done. Throughput is one result per N_NIBBLES+1 cycles back-to-back.
- start while busy=1: ignored, no queuing. Operands and the in-flight result are unaffected.
- Operand inputs are don't-care except at the accepting edge. Changes to a/b during RUN must not affect the result.
- sum during RUN: nibbles below idx hold new values, nibbles at and above idx hold the previous result. Consumers use sum only when done=1 or while in IDLE after done.
- cout changes only on the final RUN edge. It is not updated per nibble.
- Arithmetic: unsigned, modulo 2^W; {cout,sum} = a + b + cin exactly. No signed overflow flag.
- idx width: clog2(N_NIBBLES). It must never index past the top nibble. Wrap is prevented by the DONE transition, not by modulo arithmetic.
- Reset mid-RUN: abort immediately and return to reset values. No done pulse is issued for the aborted operation.
- reset and start in the same cycle: reset wins.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), NIBBLE_W=4.
- Sub-module: instantiate the team's existing 4-bit ripple-carry adder B_4xFullAdderRipple (ports: cin, a[3:0], b[3:0], cout, sum[3:0]) unchanged as the single datapath slice.
- Operand nibble mux, result write-back and FSM live in this block.

Test Plan:
- Basic: reset, then start with a=16'h1234, b=16'h0FCD, cin=0 -> done exactly 5 cycles after the accepting edge; sum=16'h2201, cout=0; busy high for 4 cycles.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Then a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
- Start while busy: accept a=16'h0001, b=16'h0001; pulse start with a=16'h00FF, b=16'h0001 two cycles later -> ignored; done once with sum=16'h0002, cout=0; no second done.
- Operand change in RUN: accept a=16'h8000, b=16'h8000; drive a=b=0 next cycle -> sum=16'h0000, cout=1.
- Back-to-back: hold start=1 with a=16'h0F0F, b=16'h00F1 then a=16'h1111, b=16'h2222 at DONE -> done pulses 5 cycles apart; results 16'h1000/cout0, then 16'h3333/cout0.
- Reset mid-op: assert reset on the 2nd RUN cycle -> next cycle state IDLE, sum=0, cout=0, done never pulses; a subsequent start completes normally.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
// Holds the nibble slice width and the sequencer state encoding.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Team 4-bit ripple-carry adder slice, used as the single datapath element
// of the nibble-serial adder.
module B_4xFullAdderRipple (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       cout,
    output logic [3:0] sum
);

    logic [4:0] carry;

    always_comb begin
        carry[0] = cin;
        sum      = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide unsigned adder built from one 4-bit slice reused once per clock,
// least significant nibble first, with a one-cycle done pulse at the end.
module nibble_serial_add_ctrl #(
    parameter int N_NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [4*N_NIBBLES-1:0]   a,
    input  logic [4*N_NIBBLES-1:0]   b,
    input  logic                     cin,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [4*N_NIBBLES-1:0]   sum,
    output logic                     cout
);

    import nibble_serial_add_ctrl_pkg::*;

    localparam int W     = NIBBLE_W * N_NIBBLES;
    localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

    state_t           state_q;
    logic [W-1:0]     opA_q;
    logic [W-1:0]     opB_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [IDX_W-1:0] idx_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [NIBBLE_W-1:0] nibA;
    logic [NIBBLE_W-1:0] nibB;
    logic [NIBBLE_W-1:0] nibSum;
    logic                nibCout;

    assign nibA = opA_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign nibB = opB_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    B_4xFullAdderRipple uSlice (
        .cin  (carry_q),
        .a    (nibA),
        .b    (nibB),
        .cout (nibCout),
        .sum  (nibSum)
    );

    // idx stops at the top nibble; leaving RUN is what prevents it wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        opA_q   <= a;
                        opB_q   <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= nibSum;
                    carry_q <= nibCout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= nibCout;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: directed scenarios plus
// randomized operands compared against a plain arithmetic reference.
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;
    localparam int LAT = N + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    nibble_serial_add_ctrl #(.N_NIBBLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference model: the whole addition as one wide unsigned sum.
    function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    // Starts one operation from a negedge and reports what was observed; no checking here.
    task automatic runOp(input logic [W-1:0] aIn, input logic [W-1:0] bIn, input logic cinIn,
                         output int latency, output int busyCycles,
                         output logic [W-1:0] sumOut, output logic coutOut);
        start = 1'b1; a = aIn; b = bIn; cin = cinIn;
        @(posedge clk);
        latency = -1; busyCycles = 0; sumOut = '0; coutOut = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (busy) busyCycles++;
            if (done) begin
                latency = n; sumOut = sum; coutOut = cout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready, busy, done, sum, cout} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got ready=%b busy=%b done=%b sum=%h cout=%b, want 1 0 0 0000 0",
                     ready, busy, done, sum, cout);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc; logic [W-1:0] s; logic c;
        runOp(16'h1234, 16'h0FCD, 1'b0, lat, bc, s, c);
        checks++;
        if (lat !== LAT) begin
            errors++; $display("[TB] FAIL basic_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (bc !== N) begin
            errors++; $display("[TB] FAIL basic_busy_cycles: got %0d want %0d", bc, N);
        end
        checks++;
        if ({c, s} !== 17'h02201) begin
            errors++; $display("[TB] FAIL basic_result: got cout=%b sum=%h want cout=0 sum=2201", c, s);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_ready_at_done: got %b want 1", ready);
        end
        @(negedge clk);
    endtask

    task automatic test_carry_ripple();
        int lat, bc; logic [W-1:0] s; logic c;
        runOp(16'hFFFF, 16'h0001, 1'b0, lat, bc, s, c);
        checks++;
        if ({c, s} !== 17'h10000) begin
            errors++; $display("[TB] FAIL ripple_b1: got cout=%b sum=%h want cout=1 sum=0000", c, s);
        end
        @(negedge clk);
        runOp(16'hFFFF, 16'h0000, 1'b1, lat, bc, s, c);
        checks++;
        if ({c, s} !== 17'h10000) begin
            errors++; $display("[TB] FAIL ripple_cin: got cout=%b sum=%h want cout=1 sum=0000", c, s);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL idle_hold: got ready=%b busy=%b done=%b cout=%b sum=%h want 1 0 0 1 0000",
                     ready, busy, done, cout, sum);
        end
    endtask

    task automatic test_start_while_busy();
        int doneCount = 0;
        logic [W-1:0] s = '0; logic c = 1'b0;
        start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 2) begin start = 1'b1; a = 16'h00FF; b = 16'h0001; end
            if (done) begin doneCount++; s = sum; c = cout; end
        end
        checks++;
        if (doneCount !== 1) begin
            errors++; $display("[TB] FAIL busy_start_done_count: got %0d want 1", doneCount);
        end
        checks++;
        if ({c, s} !== 17'h00002) begin
            errors++; $display("[TB] FAIL busy_start_result: got cout=%b sum=%h want cout=0 sum=0002", c, s);
        end
    endtask

    task automatic test_operand_change();
        int lat = -1; logic [W-1:0] s = '0; logic c = 1'b0;
        start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0; a = '0; b = '0;
            if (done) begin lat = n; s = sum; c = cout; break; end
        end
        checks++;
        if (lat !== LAT || {c, s} !== 17'h10000) begin
            errors++;
            $display("[TB] FAIL operand_change: got lat=%0d cout=%b sum=%h want lat=%0d cout=1 sum=0000",
                     lat, c, s, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1 = -1; int lat2 = -1;
        logic [W-1:0] s1 = '0; logic [W-1:0] s2 = '0; logic c1 = 1'b1; logic c2 = 1'b1;
        start = 1'b1; a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat1 = n; s1 = sum; c1 = cout;
                a = 16'h1111; b = 16'h2222;
                break;
            end
        end
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat2 = n; s2 = sum; c2 = cout; break; end
        end
        checks++;
        if (lat1 !== LAT || {c1, s1} !== 17'h01000) begin
            errors++;
            $display("[TB] FAIL b2b_first: got lat=%0d cout=%b sum=%h want lat=%0d cout=0 sum=1000",
                     lat1, c1, s1, LAT);
        end
        checks++;
        if (lat2 !== LAT || {c2, s2} !== 17'h03333) begin
            errors++;
            $display("[TB] FAIL b2b_second: got spacing=%0d cout=%b sum=%h want spacing=%0d cout=0 sum=3333",
                     lat2, c2, s2, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int doneCount = 0;
        int lat, bc; logic [W-1:0] s; logic c; logic [W:0] exp;
        start = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, busy, done, sum, cout} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: got ready=%b busy=%b done=%b sum=%h cout=%b want 1 0 0 0000 0",
                     ready, busy, done, sum, cout);
        end
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checks++;
        if (doneCount !== 0) begin
            errors++; $display("[TB] FAIL reset_no_done: got %0d done pulses want 0", doneCount);
        end
        exp = refAdd(16'h4321, 16'h8765, 1'b0);
        runOp(16'h4321, 16'h8765, 1'b0, lat, bc, s, c);
        checks++;
        if (lat !== LAT || {c, s} !== exp) begin
            errors++;
            $display("[TB] FAIL after_reset_op: got lat=%0d cout=%b sum=%h want lat=%0d %h",
                     lat, c, s, LAT, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bc; logic [W-1:0] s; logic c;
        logic [W-1:0] ra, rb; logic rc; logic [W:0] exp;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = refAdd(ra, rb, rc);
            runOp(ra, rb, rc, lat, bc, s, c);
            checks++;
            if (lat !== LAT || {c, s} !== exp) begin
                errors++;
                $display("[TB] FAIL random_%0d: a=%h b=%h cin=%b got lat=%0d {cout,sum}=%h want lat=%0d %h",
                         i, ra, rb, rc, lat, {c, s}, LAT, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_start_while_busy();
        test_operand_change();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
